// File: rtl/fft_frame_buffer.sv
// Frame buffer between the FFT core output and main_fsm: captures one natural-order frame,
// tracks the peak-magnitude bin in the lower half, then replays the frame one bin per cycle.
module fft_frame_buffer #(
    parameter int unsigned N_BINS = 512,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 18
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          fft_xk_index,
    input  logic signed [DATA_W-1:0]   fft_xk_re,
    input  logic signed [DATA_W-1:0]   fft_xk_im,
    input  logic                       fft_dv,
    output logic                       fft_done,
    output logic [ADDR_W-1:0]          fft_address,
    output logic [2*DATA_W-1:0]        fft_data,
    output logic                       fft_read_valid,
    output logic [ADDR_W-1:0]          peak_bin,
    output logic [DATA_W:0]            peak_mag,
    output logic                       overrun
);

    localparam int unsigned MagW = DATA_W + 1;
    localparam logic [ADDR_W-1:0] LastBin = ADDR_W'(N_BINS - 1);
    localparam logic [ADDR_W-1:0] FirstCand = ADDR_W'(1);
    localparam logic [ADDR_W:0] PlayEnd = (ADDR_W + 1)'(N_BINS);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StPlayout
    } state_e;

    state_e state_q, state_d;

    logic [2*DATA_W-1:0] mem [N_BINS];

    logic [DATA_W-1:0] abs_re, abs_im;
    logic [MagW-1:0]   mag;
    logic              idx_zero, idx_last, idx_cand;

    logic              wr_en, rd_en, track_start, done_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0] best_bin_q;
    logic [MagW-1:0]   best_mag_q;

    logic              done_q, valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2*DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] peak_bin_q;
    logic [MagW-1:0]   peak_mag_q;

    // Negating the most negative value yields the same bit pattern, which read as unsigned is
    // exactly 2^(DATA_W-1), so the magnitude never wraps.
    always_comb begin
        abs_re = fft_xk_re[DATA_W-1] ? DATA_W'(-fft_xk_re) : DATA_W'(fft_xk_re);
        abs_im = fft_xk_im[DATA_W-1] ? DATA_W'(-fft_xk_im) : DATA_W'(fft_xk_im);
        mag    = MagW'(abs_re) + MagW'(abs_im);
    end

    // Only bins 1..N_BINS/2-1 compete: DC and the mirrored upper half are excluded.
    assign idx_zero = (fft_xk_index == '0);
    assign idx_last = (fft_xk_index == LastBin);
    assign idx_cand = !idx_zero && !fft_xk_index[ADDR_W-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        track_start = 1'b0;
        done_d      = 1'b0;
        overrun     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fft_dv && idx_zero) begin
                    wr_en       = 1'b1;
                    track_start = 1'b1;
                    state_d     = StCapture;
                end
            end
            StCapture: begin
                if (fft_dv) begin
                    wr_en = 1'b1;
                    if (idx_zero) begin
                        overrun     = 1'b1;
                        track_start = 1'b1;
                    end else if (idx_last) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StPlayout;
                    end
                end
            end
            StPlayout: begin
                overrun = fft_dv;
                if (cnt_q == PlayEnd) begin
                    state_d = StIdle;
                end else begin
                    rd_en = 1'b1;
                    cnt_d = cnt_q + (ADDR_W + 1)'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strict greater-than with ascending indices keeps the lowest bin on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_bin_q <= '0;
            best_mag_q <= '0;
        end else if (track_start) begin
            best_bin_q <= FirstCand;
            best_mag_q <= '0;
        end else if (wr_en && idx_cand && (mag > best_mag_q)) begin
            best_bin_q <= fft_xk_index;
            best_mag_q <= mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q     <= 1'b0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
        end else begin
            done_q <= done_d;
            if (done_d) begin
                peak_bin_q <= best_bin_q;
                peak_mag_q <= best_mag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[fft_xk_index] <= {fft_xk_re, fft_xk_im};
        end
    end

    // Address travels with the read so fft_address and fft_data line up; both hold after playout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                addr_q <= cnt_q[ADDR_W-1:0];
                data_q <= mem[cnt_q[ADDR_W-1:0]];
            end
        end
    end

    assign fft_done       = done_q;
    assign fft_read_valid = valid_q;
    assign fft_address    = addr_q;
    assign fft_data       = data_q;
    assign peak_bin       = peak_bin_q;
    assign peak_mag       = peak_mag_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: capture, peak tracking, restart, drop-during-playout,
// and reset abort, with expected frames and peaks computed by hand in each test.
module tb_fft_frame_buffer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [8:0]         fft_xk_index;
    logic signed [17:0] fft_xk_re, fft_xk_im;
    logic               fft_dv;
    logic               fft_done;
    logic [8:0]         fft_address;
    logic [35:0]        fft_data;
    logic               fft_read_valid;
    logic [8:0]         peak_bin;
    logic [18:0]        peak_mag;
    logic               overrun;

    int n_vec = 0;
    int n_err = 0;

    logic signed [17:0] exp_re [512];
    logic signed [17:0] exp_im [512];
    logic [8:0]         obs_addr [512];
    logic [35:0]        obs_data [512];
    int obs_first, obs_last, obs_beats, obs_ovr, obs_done;

    fft_frame_buffer #(.N_BINS(512), .ADDR_W(9), .DATA_W(18)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fft_xk_index   (fft_xk_index),
        .fft_xk_re      (fft_xk_re),
        .fft_xk_im      (fft_xk_im),
        .fft_dv         (fft_dv),
        .fft_done       (fft_done),
        .fft_address    (fft_address),
        .fft_data       (fft_data),
        .fft_read_valid (fft_read_valid),
        .peak_bin       (peak_bin),
        .peak_mag       (peak_mag),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic clear_frame();
        for (int k = 0; k < 512; k++) begin
            exp_re[k] = '0;
            exp_im[k] = '0;
        end
    endtask

    task automatic ramp_frame(input int scale_re, input int scale_im);
        for (int k = 0; k < 512; k++) begin
            exp_re[k] = 18'(k * scale_re);
            exp_im[k] = 18'(k * scale_im);
        end
    endtask

    // Leaves the bench 1 ns into the cycle after the last bin was sampled.
    task automatic drive_bins(input int lo, input int hi, input bit gap);
        for (int k = lo; k <= hi; k++) begin
            fft_dv       = 1'b1;
            fft_xk_index = 9'(k);
            fft_xk_re    = exp_re[k];
            fft_xk_im    = exp_im[k];
            @(posedge clk);
            #1;
            if (gap && k < hi) begin
                fft_dv = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        fft_dv = 1'b0;
    endtask

    // Starts at the fft_done cycle; i==0 is the first cycle a beat may appear.
    task automatic collect_playout(input bit inject);
        obs_beats = 0;
        obs_first = -1;
        obs_last  = -1;
        obs_ovr   = 0;
        obs_done  = 0;
        for (int i = 0; i < 516; i++) begin
            @(posedge clk);
            #1;
            fft_dv       = inject && (i % 3 == 0) && (i < 510);
            fft_xk_index = 9'd7;
            @(negedge clk);
            if (fft_read_valid) begin
                if (obs_beats < 512) begin
                    obs_addr[obs_beats] = fft_address;
                    obs_data[obs_beats] = fft_data;
                end
                obs_beats++;
                if (obs_first < 0) obs_first = i;
                obs_last = i;
            end
            if (overrun) obs_ovr++;
            if (fft_done) obs_done++;
        end
        fft_dv = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fft_dv = 1'b0;
        fft_xk_index = '0;
        fft_xk_re = '0;
        fft_xk_im = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({fft_done, fft_read_valid, overrun} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000", {fft_done, fft_read_valid, overrun});
        end
        n_vec++;
        if (fft_address !== 9'd0 || fft_data !== 36'd0) begin
            n_err++;
            $display("FAIL reset_data: got addr %0d data %h want 0/0", fft_address, fft_data);
        end
        n_vec++;
        if (peak_bin !== 9'd0 || peak_mag !== 19'd0) begin
            n_err++;
            $display("FAIL reset_peak: got %0d/%0d want 0/0", peak_bin, peak_mag);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Mid-frame join from IDLE: dropped silently.
        fft_dv = 1'b1;
        fft_xk_index = 9'd5;
        fft_xk_re = 18'sd77;
        @(negedge clk);
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL idle_discard_overrun: got %b want 0", overrun);
        end
        @(posedge clk);
        #1;
        fft_dv = 1'b0;
        @(negedge clk);
        n_vec++;
        if (fft_done !== 1'b0 || fft_read_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_discard_out: got done %b valid %b want 0 0", fft_done,
                     fft_read_valid);
        end
    endtask

    task automatic test_ramp(input bit gap);
        ramp_frame(1, -1);
        drive_bins(0, 511, gap);
        @(negedge clk);
        n_vec++;
        if (fft_done !== 1'b1 || fft_read_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_done gap=%0d: got done %b valid %b want 1 0", gap, fft_done,
                     fft_read_valid);
        end
        n_vec++;
        if (peak_bin !== 9'd255 || peak_mag !== 19'd510) begin
            n_err++;
            $display("FAIL ramp_peak gap=%0d: got %0d/%0d want 255/510", gap, peak_bin, peak_mag);
        end
        collect_playout(1'b0);
        n_vec++;
        if (obs_beats !== 512 || obs_first !== 0 || obs_last !== 511 || obs_done !== 0) begin
            n_err++;
            $display("FAIL ramp_timing gap=%0d: got beats %0d first %0d last %0d done %0d want 512 0 511 0",
                     gap, obs_beats, obs_first, obs_last, obs_done);
        end
        for (int k = 0; k < 512; k++) begin
            n_vec++;
            if (obs_addr[k] !== 9'(k) || obs_data[k] !== {exp_re[k], exp_im[k]}) begin
                n_err++;
                $display("FAIL ramp_beat%0d gap=%0d: got %0d/%h want %0d/%h", k, gap,
                         obs_addr[k], obs_data[k], k, {exp_re[k], exp_im[k]});
            end
        end
    endtask

    task automatic test_peak(input string name, input logic [8:0] want_bin,
                             input logic [18:0] want_mag, input int probe);
        drive_bins(0, 511, 1'b0);
        @(negedge clk);
        n_vec++;
        if (fft_done !== 1'b1 || peak_bin !== want_bin || peak_mag !== want_mag) begin
            n_err++;
            $display("FAIL %s_peak: got done %b %0d/%0d want 1 %0d/%0d", name, fft_done,
                     peak_bin, peak_mag, want_bin, want_mag);
        end
        collect_playout(1'b0);
        n_vec++;
        if (obs_beats !== 512 || obs_data[probe] !== {exp_re[probe], exp_im[probe]}) begin
            n_err++;
            $display("FAIL %s_stream: got beats %0d bin%0d %h want 512 %h", name, obs_beats,
                     probe, obs_data[probe], {exp_re[probe], exp_im[probe]});
        end
    endtask

    task automatic test_restart();
        for (int k = 0; k < 512; k++) begin
            exp_re[k] = 18'sd3000;
            exp_im[k] = 18'sd0;
        end
        drive_bins(0, 199, 1'b0);
        ramp_frame(1, -1);
        fft_dv = 1'b1;
        fft_xk_index = 9'd0;
        fft_xk_re = exp_re[0];
        fft_xk_im = exp_im[0];
        @(negedge clk);
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL restart_overrun: got %b want 1", overrun);
        end
        @(posedge clk);
        #1;
        drive_bins(1, 511, 1'b0);
        @(negedge clk);
        n_vec++;
        if (fft_done !== 1'b1 || peak_bin !== 9'd255 || peak_mag !== 19'd510) begin
            n_err++;
            $display("FAIL restart_peak: got done %b %0d/%0d want 1 255/510", fft_done,
                     peak_bin, peak_mag);
        end
        collect_playout(1'b1);
        n_vec++;
        if (obs_ovr !== 170 || obs_done !== 0) begin
            n_err++;
            $display("FAIL playout_drop: got overruns %0d done %0d want 170 0", obs_ovr, obs_done);
        end
        n_vec++;
        if (obs_beats !== 512 || obs_first !== 0 || obs_last !== 511) begin
            n_err++;
            $display("FAIL restart_timing: got beats %0d first %0d last %0d want 512 0 511",
                     obs_beats, obs_first, obs_last);
        end
        for (int k = 0; k < 512; k++) begin
            n_vec++;
            if (obs_addr[k] !== 9'(k) || obs_data[k] !== {exp_re[k], exp_im[k]}) begin
                n_err++;
                $display("FAIL restart_beat%0d: got %0d/%h want %0d/%h", k, obs_addr[k],
                         obs_data[k], k, {exp_re[k], exp_im[k]});
            end
        end
    endtask

    task automatic test_abort();
        bit found;
        ramp_frame(1, -1);
        drive_bins(0, 511, 1'b0);
        @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (fft_read_valid && fft_address == 9'd100) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL abort_reach_bin100: got not seen want seen");
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({fft_done, fft_read_valid, overrun, fft_address, fft_data, peak_bin, peak_mag} !== '0)
        begin
            n_err++;
            $display("FAIL abort_outputs: got done %b valid %b ovr %b addr %0d data %h peak %0d/%0d want all 0",
                     fft_done, fft_read_valid, overrun, fft_address, fft_data, peak_bin, peak_mag);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (fft_read_valid !== 1'b0 || fft_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got valid %b done %b want 0 0", fft_read_valid, fft_done);
        end
        @(posedge clk);
        #1;
        ramp_frame(2, 1);
        drive_bins(0, 511, 1'b0);
        @(negedge clk);
        n_vec++;
        if (fft_done !== 1'b1 || peak_bin !== 9'd255 || peak_mag !== 19'd765) begin
            n_err++;
            $display("FAIL abort_next_peak: got done %b %0d/%0d want 1 255/765", fft_done,
                     peak_bin, peak_mag);
        end
        collect_playout(1'b0);
        n_vec++;
        if (obs_beats !== 512 || obs_first !== 0 || obs_last !== 511) begin
            n_err++;
            $display("FAIL abort_next_timing: got beats %0d first %0d last %0d want 512 0 511",
                     obs_beats, obs_first, obs_last);
        end
        for (int k = 0; k < 512; k++) begin
            n_vec++;
            if (obs_addr[k] !== 9'(k) || obs_data[k] !== {exp_re[k], exp_im[k]}) begin
                n_err++;
                $display("FAIL abort_next_beat%0d: got %0d/%h want %0d/%h", k, obs_addr[k],
                         obs_data[k], k, {exp_re[k], exp_im[k]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp(1'b0);
        test_ramp(1'b1);

        clear_frame();
        exp_re[0]   = 18'sd9000;
        exp_re[10]  = 18'sd1000;
        exp_re[20]  = -18'sd600;
        exp_im[20]  = 18'sd400;
        exp_re[300] = 18'sd5000;
        test_peak("tie", 9'd10, 19'd1000, 20);

        clear_frame();
        exp_re[5] = 18'sh20000;
        exp_im[5] = 18'sh20000;
        test_peak("minneg", 9'd5, 19'd262144, 5);

        clear_frame();
        exp_re[400] = 18'sd12;
        test_peak("allzero", 9'd1, 19'd0, 400);

        test_restart();
        test_abort();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
